// File: rtl/bus_arbiter_rr16_pkg.sv
// ============================================================================
// Module      : bus_arbiter_rr16_pkg
// Description : Shared sizes, state encoding and one-hot helper for the
//               16-source round-robin bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arbiter_rr16_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr16_if.sv
// ============================================================================
// Module      : bus_arbiter_rr16_if
// Description : Request/grant/select bundle between the arbiter (master)
//               and the 16 register sources (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_arbiter_rr16_if;

    logic [bus_arbiter_rr16_pkg::NUM_REQ-1:0] req;
    logic [bus_arbiter_rr16_pkg::NUM_REQ-1:0] grant;
    logic [bus_arbiter_rr16_pkg::SEL_W-1:0]   se1;
    logic                                     bus_valid;
    logic                                     preempt;

    modport master (
        input  req,
        output grant,
        output se1,
        output bus_valid,
        output preempt
    );

    modport slave (
        output req,
        input  grant,
        input  se1,
        input  bus_valid,
        input  preempt
    );

endinterface

`default_nettype wire

// File: rtl/bus_arbiter_rr16_rr_pick16.sv
// ============================================================================
// Module      : rr_pick16
// Description : Combinational rotate-priority encoder; returns the first set
//               mask bit searching upward from (last+1) with wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick16
    import bus_arbiter_rr16_pkg::*;
(
    input  wire logic [NUM_REQ-1:0] mask,
    input  wire logic [SEL_W-1:0]   last,
    output logic      [SEL_W-1:0]   idx,
    output logic                    found
);

    logic [SEL_W-1:0] cand;

    // Offsets 1..16 visit every index exactly once; offset 16 wraps back to last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + SEL_W'(i);
            if (!found && mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_rr16.sv
// ============================================================================
// Module      : bus_arbiter_rr16
// Description : Round-robin arbiter/sequencer for the 16-source register bus
//               with bounded hold time and forced preemption.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_rr16
    import bus_arbiter_rr16_pkg::*;
#(
    parameter int MAX_HOLD = 8
)(
    input  wire logic           clk,
    input  wire logic           rst,
    bus_arbiter_rr16_if.master  bus
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_e             state_q,   state_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic [SEL_W-1:0]   sel_q,     sel_d;
    logic [SEL_W-1:0]   last_q,    last_d;
    logic [7:0]         cnt_q,     cnt_d;
    logic               valid_q,   valid_d;
    logic               preempt_q, preempt_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic               owner_req;
    logic [NUM_REQ-1:0] pick_mask;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;

    assign owner_oh  = onehot16(sel_q);
    assign owner_req = |(bus.req & owner_oh);

    // While owned the owner bit is excluded, so a release or timeout always
    // hands over to someone else; on release the owner bit is already low.
    assign pick_mask = (state_q == ST_OWNED) ? (bus.req & ~owner_oh) : bus.req;

    rr_pick16 u_pick (
        .mask  (pick_mask),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;

        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                state_d = ST_OWNED;
                grant_d = onehot16(pick_idx);
                sel_d   = pick_idx;
                last_d  = pick_idx;
                cnt_d   = 8'd1;
                valid_d = 1'b1;
            end
        end else begin
            if (!owner_req) begin
                if (pick_found) begin
                    grant_d = onehot16(pick_idx);
                    sel_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end else if (cnt_q < MAX_HOLD_C) begin
                cnt_d = cnt_q + 8'd1;
            end else if (pick_found) begin
                grant_d   = onehot16(pick_idx);
                sel_d     = pick_idx;
                last_d    = pick_idx;
                cnt_d     = 8'd1;
                preempt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            last_q    <= SEL_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.se1       = sel_q;
    assign bus.bus_valid = valid_q;
    assign bus.preempt   = preempt_q;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_rr16.sv
// ============================================================================
// Module      : tb_bus_arbiter_rr16
// Description : Directed self-checking bench for bus_arbiter_rr16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_rr16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    bus_arbiter_rr16_if bus_if ();

    bus_arbiter_rr16 #(.MAX_HOLD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] g, input logic [3:0] s,
                           input logic v, input logic p);
        chk({tag, ".grant"},     bus_if.grant,            g);
        chk({tag, ".se1"},       16'(bus_if.se1),         16'(s));
        chk({tag, ".bus_valid"}, 16'(bus_if.bus_valid),   16'(v));
        chk({tag, ".preempt"},   16'(bus_if.preempt),     16'(p));
    endtask

    logic [15:0] prev_req;
    int          wait_cnt [16];
    int          max_wait;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus_if.req = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        chk_out("reset", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Single requester, one-cycle latency, then release to idle
        bus_if.req = 16'h0001;
        tick();
        chk_out("single_grant", 16'h0001, 4'd0, 1'b1, 1'b0);
        bus_if.req = 16'h0000;
        tick();
        chk_out("single_release", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        chk_out("idle_hold", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Pointer is at R0, so R15 wins first; owners release back-to-back
        bus_if.req = 16'h8001;
        tick(); chk_out("rr_a1", 16'h8000, 4'd15, 1'b1, 1'b0);
        tick(); chk_out("rr_a2", 16'h8000, 4'd15, 1'b1, 1'b0);
        bus_if.req = 16'h0001;
        tick(); chk_out("rr_b1", 16'h0001, 4'd0, 1'b1, 1'b0);
        bus_if.req = 16'h8001;
        tick(); chk_out("rr_b2", 16'h0001, 4'd0, 1'b1, 1'b0);
        bus_if.req = 16'h8000;
        tick(); chk_out("rr_c1", 16'h8000, 4'd15, 1'b1, 1'b0);
        bus_if.req = 16'h8001;
        tick(); chk_out("rr_c2", 16'h8000, 4'd15, 1'b1, 1'b0);
        bus_if.req = 16'h0001;
        tick(); chk_out("rr_d1", 16'h0001, 4'd0, 1'b1, 1'b0);
        bus_if.req = 16'h0000;
        tick(); chk_out("rr_idle", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Two persistent requesters alternate every MAX_HOLD cycles
        bus_if.req = 16'h0024;
        for (int i = 1; i <= 8; i++) begin
            tick(); chk_out("hold_r2", 16'h0004, 4'd2, 1'b1, 1'b0);
        end
        tick(); chk_out("preempt_to_r5", 16'h0020, 4'd5, 1'b1, 1'b1);
        for (int i = 2; i <= 8; i++) begin
            tick(); chk_out("hold_r5", 16'h0020, 4'd5, 1'b1, 1'b0);
        end
        tick(); chk_out("preempt_to_r2", 16'h0004, 4'd2, 1'b1, 1'b1);
        bus_if.req = 16'h0000;
        tick(); chk_out("idle2", 16'h0000, 4'd2, 1'b0, 1'b0);

        // Lone requester saturates; a late competitor forces a handover
        bus_if.req = 16'h0008;
        for (int i = 0; i < 20; i++) begin
            tick(); chk_out("lone_r3", 16'h0008, 4'd3, 1'b1, 1'b0);
        end
        bus_if.req = 16'h0208;
        tick(); chk_out("late_r9", 16'h0200, 4'd9, 1'b1, 1'b1);
        bus_if.req = 16'h0000;
        tick(); chk_out("idle3", 16'h0000, 4'd9, 1'b0, 1'b0);

        // Reset mid-grant restores the pointer so R0 wins next
        bus_if.req = 16'h0080;
        tick(); chk_out("own_r7", 16'h0080, 4'd7, 1'b1, 1'b0);
        tick();
        bus_if.req = 16'hFFFF;
        rst = 1'b1;
        tick(); chk_out("mid_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(); chk_out("post_reset", 16'h0001, 4'd0, 1'b1, 1'b0);

        // Random phase: slowly varying requests, invariant and starvation monitor
        for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
        max_wait = 15 * 8 + 15;
        for (int c = 0; c < 10000; c++) begin
            bus_if.req = bus_if.req ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            prev_req   = bus_if.req;
            tick();
            chk("rand_onehot", 16'(($countones(bus_if.grant) <= 1)), 16'd1);
            chk("rand_sel_valid", 16'(bus_if.grant[bus_if.se1]), 16'(bus_if.bus_valid));
            chk("rand_valid_nz", 16'(bus_if.bus_valid), 16'(bus_if.grant != 16'h0000));
            for (int i = 0; i < 16; i++) begin
                if (prev_req[i] && !bus_if.grant[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) begin
                    chk("rand_starve", 16'(wait_cnt[i]), 16'(max_wait));
                    wait_cnt[i] = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_arbiter_rr16.md
Name: bus_arbiter_rr16

Overview:
- Round-robin arbiter and sequencer for the 16-source shared register bus.
- Accepts level requests from the 16 register sources (R0..R15) and grants exactly one owner at a time.
- Drives the 4-bit bus-select code into the 16-to-1 bus mux, plus a one-hot grant vector back to the sources.
- Enforces a maximum hold time so that no source can starve the others (for example, the multiplier datapath's accumulator register).

Parameters:
- NUM_REQ, 16, number of requesters; fixed at 16 because the select code is 4 bits.
- SEL_W, 4, width of the select code.
- MAX_HOLD, 8, maximum consecutive granted cycles before forced preemption when others are waiting; legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  level request; bit i set means source Ri wants the bus.
- grant  output  16  one-hot grant, registered; all-zero when no owner.
- se1  output  4  bus-mux select code (index of the current owner), registered.
- bus_valid  output  1  high while grant is non-zero.
- preempt  output  1  one-cycle pulse on the edge where the owner is forcibly replaced.

Behaviour:
- Reset values:
  - grant=0, se1=0, bus_valid=0, preempt=0.
  - Internal last-owner pointer = 15, so the first arbitration favours R0.
  - Hold counter = 0; state = IDLE.
- States:
  - IDLE: no owner.
  - OWNED: grant[se1]=1.
- Pick function: first set bit of the request mask, searching from (last+1) mod 16 upward with wrap-around past 15 to 0.
- IDLE transitions:
  - If any req bit is sampled high at edge n, then after edge n: grant=onehot(pick), se1=pick, bus_valid=1, last=pick, counter=1, state=OWNED.
  - Latency from req to grant is one clock.
- OWNED, owner's req sampled low:
  - Release. If other requests are pending, re-arbitrate on the same edge with no idle bubble (back-to-back grant).
  - Otherwise go to IDLE: grant=0, bus_valid=0, se1 retains its last value.
- OWNED, owner's req high and counter < MAX_HOLD:
  - Keep the grant; counter increments.
- OWNED, owner's req high, counter == MAX_HOLD, and any other request pending:
  - Forced handover to pick(req with owner bit masked off).
  - preempt=1 for one cycle; counter=1.
- OWNED, owner's req high, counter == MAX_HOLD, and no other request pending:
  - Owner keeps the bus; counter saturates at MAX_HOLD; no preempt.
  - A later request from another source causes handover on the next edge.
- Invariants:
  - grant is always zero or one-hot.
  - grant[se1]==bus_valid.
  - se1 changes only on a grant edge.
- Counter width is 8 bits; it never wraps.
- Simultaneous events:
  - A new req from the source the pointer favours, arriving on the owner's release edge, wins only if it is next in rotation order.
  - req bits from non-owners changing mid-grant have no effect until release or timeout.
- rst asserted mid-grant: all outputs return to reset values on that edge regardless of req.
- req == 0 in IDLE: state holds; se1 is unchanged.

Decomposition:
- Shared package (bus_pkg):
  - NUM_REQ=16, SEL_W=4.
  - State encoding: IDLE=1'b0, OWNED=1'b1.
  - Onehot-from-index helper.
- One natural sub-module: rr_pick16.
  - Combinational rotate-priority encoder.
  - Inputs: 16-bit mask, 4-bit last pointer.
  - Outputs: 4-bit index and found flag.
  - Instanced once. The main block masks the owner bit in before calling it on the timeout path.

Test Plan:
- Reset then req=16'h0001 -> one edge later grant=16'h0001, se1=0, bus_valid=1; drop req -> next edge grant=0, bus_valid=0, se1 stays 0.
- req=16'h8001 held, owner releasing after 2 cycles each time -> grant order R0, R15, R0, R15 with no idle cycle between grants.
- req=16'h0024 constant, MAX_HOLD=8 -> R2 granted 8 cycles, preempt pulse, R5 granted 8 cycles, preempt, R2 again.
- Only R3 requests for 20 cycles -> grant stays 16'h0008 throughout with preempt=0; assert req[9] at cycle 20 -> grant=16'h0200 and preempt=1 on the next edge.
- Owner R7 mid-grant, assert rst for one cycle with req=16'hFFFF -> grant=0, se1=0, bus_valid=0; then next grant goes to R0.
- Random req for 10k cycles, checked by monitor -> grant always zero or one-hot, grant[se1]==bus_valid, no source waits more than 15*MAX_HOLD+15 cycles.
